// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned MIN_WIDTH     = 2;
  localparam int unsigned MAX_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_ctrl_full_adder_cell.sv
// One-bit full adder built structurally from two half adders and an OR.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_c_o,
  output logic carry_c_o
);

  assign sum_c_o   = a_i ^ b_i;
  assign carry_c_o = a_i & b_i;

endmodule

module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_c_o,
  output logic carry_c_o
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a_i       (a_i),
    .b_i       (b_i),
    .sum_c_o   (s0),
    .carry_c_o (c0)
  );

  half_adder u_ha1 (
    .a_i       (s0),
    .b_i       (c_i),
    .sum_c_o   (sum_c_o),
    .carry_c_o (c1)
  );

  assign carry_c_o = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell sequenced LSB first over WIDTH clocks,
// with registered sum/cout held until the next completion.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_ctrl_if.slave bus_if
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic s_bit;
  logic c_bit;

  full_adder_cell u_cell (
    .a_i       (ra_q[0]),
    .b_i       (rb_q[0]),
    .c_i       (carry_q),
    .sum_c_o   (s_bit),
    .carry_c_o (c_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // busy/done are computed from the next state so they are registered alongside it
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus_if.start) begin
          ra_d    = bus_if.a;
          rb_d    = bus_if.b;
          carry_d = bus_if.cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ra_d    = {1'b0, ra_q[WIDTH-1:1]};
        rb_d    = {1'b0, rb_q[WIDTH-1:1]};
        acc_d   = {s_bit, acc_q[WIDTH-1:1]};
        carry_d = c_bit;
        cnt_d   = cnt_q + CNT_W'(1);
        busy_d  = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {s_bit, acc_q[WIDTH-1:1]};
          cout_d  = c_bit;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus_if.busy = busy_q;
  assign bus_if.done = done_q;
  assign bus_if.sum  = sum_q;
  assign bus_if.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks of serial_adder_ctrl against an arithmetic reference.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // last completed result as {cout, sum}, from the reference model
  logic [W:0] prev_res;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] exp;
    int nbusy;
    bit got;
    exp = model(a, b, c);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = c;
    @(negedge clk);
    bus.start = 1'b0;
    nbusy = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (bus.busy) nbusy++;
        check("hold_result", 32'({bus.cout, bus.sum}), 32'(prev_res));
        @(negedge clk);
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      end
    end
    check("done_seen", 32'(got), 32'(1));
    check("busy_cycles", 32'(nbusy), 32'(W));
    check("busy_at_done", 32'(bus.busy), 32'(0));
    check("sum", 32'(bus.sum), 32'(exp[W-1:0]));
    check("cout", 32'(bus.cout), 32'(exp[W]));
    prev_res = exp;
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'(0));
  endtask

  initial begin
    int ndone;
    int t0;
    logic [W-1:0] ra, rb;
    logic rc;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    prev_res = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // reset then idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_idle", 32'({bus.busy, bus.done, bus.cout, bus.sum}), 32'(0));
    end

    run_op(8'h35, 8'h4A, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1);

    // start during SHIFT must be ignored while a/b churn
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        check("busy_prot_sum", 32'(bus.sum), 32'(8'h03));
        check("busy_prot_cout", 32'(bus.cout), 32'(0));
      end
      if (i == 3) begin
        bus.start = 1'b1; bus.a = 8'hF0; bus.b = 8'h0F;
      end else begin
        bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom);
      end
    end
    check("busy_prot_ndone", 32'(ndone), 32'(1));
    prev_res = 9'h003;

    // back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    ndone = 0;
    t0 = 0;
    for (int cyc = 1; cyc <= 60 && ndone < 2; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        if (ndone == 0) begin
          check("b2b_sum0", 32'({bus.cout, bus.sum}), 32'(9'h030));
          t0 = cyc;
          bus.a = 8'h80; bus.b = 8'h80;
        end else begin
          check("b2b_sum1", 32'({bus.cout, bus.sum}), 32'(9'h100));
          check("b2b_gap", 32'(cyc - t0), 32'(W + 1));
          bus.start = 1'b0;
        end
        ndone++;
      end
    end
    check("b2b_ndone", 32'(ndone), 32'(2));
    @(negedge clk);
    check("b2b_idle", 32'({bus.busy, bus.done}), 32'(0));
    prev_res = 9'h100;

    // reset on the 4th SHIFT cycle discards the operation
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(bus.busy), 32'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("after_reset", 32'({bus.busy, bus.done, bus.cout, bus.sum}), 32'(0));
      @(negedge clk);
    end
    prev_res = '0;
    run_op(8'h01, 8'h01, 1'b0);

    // randomized operations
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
